seg7_scan_display: RTL and testbench

SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

---
 rtl/seg7_scan_display.sv | 143 ++++++++++++++
 tb/tb_seg7_scan_display.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed 7-segment driver with BCD decode, leading-zero blanking,
// and a pending/display double buffer. New data is swapped in only at a frame boundary.
module seg7_scan_display #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int SCAN_HZ  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic        ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        err,
    output logic        overrun
);

    localparam int DIV = CLK_FREQ / SCAN_HZ;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    function automatic logic has_non_bcd(input logic [15:0] d);
        return (d[3:0] > 4'd9) || (d[7:4] > 4'd9) || (d[11:8] > 4'd9) || (d[15:12] > 4'd9);
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   disp_q, disp_d, pend_q, pend_d;
    logic [3:0]    disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
    logic          pend_full_q, pend_full_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d, ovr_q, ovr_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          scan_tick, commit, accept, blank_s;
    logic [3:0]    nib_s;

    // Next-state logic: prescaler, digit index, load handshake, commit, output decode
    always_comb begin
        scan_tick   = (cnt_q == CW'(DIV - 1));
        commit      = scan_tick && (idx_q == 2'd3) && pend_full_q;
        // a commit cycle always has ready low, so a coinciding load is refused
        accept      = load && ready_q && !commit;

        cnt_d       = scan_tick ? '0 : cnt_q + CW'(1);
        idx_d       = scan_tick ? idx_q + 2'd1 : idx_q;

        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        err_d       = err_q;
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        if (commit) begin
            disp_d      = pend_q;
            disp_dp_d   = pend_dp_q;
            err_d       = has_non_bcd(pend_q);
            pend_full_d = 1'b0;
        end else if (accept) begin
            pend_d      = data_in;
            pend_dp_d   = dp_in;
            pend_full_d = 1'b1;
        end else begin
            pend_full_d = pend_full_q;
        end
        ready_d = !pend_full_d;
        ovr_d   = ovr_q || (load && !accept);

        nib_s = disp_q[{idx_q, 2'b00} +: 4];
        case (idx_q)
            2'd0:    blank_s = 1'b0;
            2'd1:    blank_s = blank_lz && (disp_q[15:4] == 12'd0);
            2'd2:    blank_s = blank_lz && (disp_q[15:8] == 8'd0);
            2'd3:    blank_s = blank_lz && (disp_q[15:12] == 4'd0);
            default: blank_s = 1'b0;
        endcase
        an_d  = ~(4'b0001 << idx_q);
        seg_d = blank_s ? 7'b1111111 : decode(nib_s);
        dp_d  = ~disp_dp_q[idx_q];
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            disp_q      <= 16'd0;
            disp_dp_q   <= 4'd0;
            pend_q      <= 16'd0;
            pend_dp_q   <= 4'd0;
            pend_full_q <= 1'b0;
            ready_q     <= 1'b1;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
            an_q        <= 4'b1111;
            seg_q       <= 7'b1111111;
            dp_q        <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            pend_q      <= pend_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign ready   = ready_q;
    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;
    assign err     = err_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display (DIV=10): expected digit outputs are queued per
// frame and popped cycle by cycle against the DUT.
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        rst, load, blank_lz;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        ready, dp, err, overrun;
    logic [3:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;
    exp_t q[$];

    int          la = -1, lb = -1;
    logic [15:0] ld = 16'd0, ldb = 16'd0;
    logic [3:0]  lp = 4'd0;

    seg7_scan_display #(.CLK_FREQ(1000), .SCAN_HZ(100)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
        .blank_lz(blank_lz), .ready(ready), .an(an), .seg(seg), .dp(dp),
        .err(err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic exp_t expect_digit(input logic [15:0] d, input logic [3:0] p,
                                          input logic bl, input int k);
        exp_t e;
        logic [15:0] upper;
        logic blank;
        upper   = d >> (4 * k);
        blank   = bl && (k > 0) && (upper == 16'd0);
        e.an    = ~(4'b0001 << k);
        e.seg   = blank ? 7'b1111111 : seg_of(upper[3:0]);
        e.dp    = ~p[k];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one 40-cycle frame starting at its first digit0 cycle, with optional loads.
    task automatic frame(input logic [15:0] d, input logic [3:0] p);
        exp_t e;
        for (int c = 0; c < 40; c++) q.push_back(expect_digit(d, p, blank_lz, c / 10));
        for (int c = 0; c < 40; c++) begin
            e = q.pop_front();
            chk("an", {12'd0, an}, {12'd0, e.an});
            chk("seg", {9'd0, seg}, {9'd0, e.seg});
            chk("dp", {15'd0, dp}, {15'd0, e.dp});
            if (la >= 0 && la < 38 && c == la + 1) chk("ready_low", {15'd0, ready}, 16'd0);
            if (c == la) begin
                load = 1'b1; data_in = ld; dp_in = lp;
            end else if (c == lb) begin
                load = 1'b1; data_in = ldb; dp_in = 4'b1111;
            end else begin
                load = 1'b0;
            end
            @(posedge clk); #1;
            load = 1'b0;
        end
        la = -1; lb = -1; lp = 4'd0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; data_in = 16'd0; dp_in = 4'd0; blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", {12'd0, an}, 16'h000f);
        chk("rst_seg", {9'd0, seg}, 16'h007f);
        chk("rst_dp", {15'd0, dp}, 16'd1);
        chk("rst_ready", {15'd0, ready}, 16'd1);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_ovr", {15'd0, overrun}, 16'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        frame(16'h0000, 4'b0000);
        la = 5; ld = 16'h1234; lp = 4'b0100; lb = 20; ldb = 16'h9999;
        frame(16'h0000, 4'b0000);
        chk("ready_after_commit", {15'd0, ready}, 16'd1);
        chk("ovr_set", {15'd0, overrun}, 16'd1);
        frame(16'h1234, 4'b0100);

        blank_lz = 1'b1;
        la = 0; ld = 16'h0007;
        frame(16'h1234, 4'b0100);
        la = 0; ld = 16'h0000;
        frame(16'h0007, 4'b0000);
        la = 0; ld = 16'h12A4; lb = 38; ldb = 16'h5555;
        frame(16'h0000, 4'b0000);
        chk("err_set", {15'd0, err}, 16'd1);
        blank_lz = 1'b0;
        la = 0; ld = 16'h1234;
        frame(16'h12A4, 4'b0000);
        chk("err_clr", {15'd0, err}, 16'd0);
        chk("ovr_sticky", {15'd0, overrun}, 16'd1);
        frame(16'h1234, 4'b0000);

        load = 1'b1; data_in = 16'h8888; dp_in = 4'b1111;
        @(posedge clk); #1;
        load = 1'b0;
        chk("ready_pend", {15'd0, ready}, 16'd0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_an", {12'd0, an}, 16'h000f);
        chk("mid_rst_seg", {9'd0, seg}, 16'h007f);
        chk("mid_rst_ready", {15'd0, ready}, 16'd1);
        chk("mid_rst_ovr", {15'd0, overrun}, 16'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        frame(16'h0000, 4'b0000);
        frame(16'h0000, 4'b0000);
        chk("post_rst_ready", {15'd0, ready}, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
